// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller: issues a one-cycle CPU clock enable and
// selects the value shown on the 7-segment display.
module cpu_run_ctrl #(
  parameter int DIV_LOG2   = 20,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_run,
  input  logic             btn_step,
  input  logic             btn_disp,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
  input  logic [31:0]      data_out,
  output logic             cpu_ce,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       disp_src,
  output logic [31:0]      disp_data,
  output logic [1:0]       state,
  output logic             halted
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Bit 0 is the step button, bit 1 the display button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       level_q;
  logic [1:0]       press_q;
  logic [DEB_W-1:0] deb_cnt_q [2];

  assign btn_raw = {btn_disp, btn_step};

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          level_q[i]   <= ~level_q[i];
          deb_cnt_q[i] <= '0;
          press_q[i]   <= ~level_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  logic                step_press, disp_press;
  state_e              state_q;
  logic                cpu_ce_q;
  logic [DIV_LOG2-1:0] div_q;
  logic [CNT_W-1:0]    cnt_q;

  assign step_press = press_q[0];
  assign disp_press = press_q[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_HALT;
      cpu_ce_q <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
    end else begin
      cpu_ce_q <= 1'b0;
      if (cpu_ce_q) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        ST_HALT: begin
          if (mode_run) begin
            state_q <= ST_RUN;
            div_q   <= '0;
          end else if (step_press) begin
            state_q  <= ST_STEP;
            cpu_ce_q <= 1'b1;
          end
        end
        ST_RUN: begin
          // mode_run and the breakpoint both win over a tick due this cycle.
          if (!mode_run) begin
            state_q <= ST_HALT;
          end else if (bp_en && (pc == bp_addr)) begin
            state_q <= ST_BREAK;
          end else begin
            div_q    <= div_q + DIV_LOG2'(1);
            cpu_ce_q <= &div_q;
          end
        end
        ST_STEP: state_q <= ST_HALT;
        ST_BREAK: begin
          if (!mode_run) begin
            state_q <= ST_HALT;
          end else if (step_press) begin
            state_q  <= ST_STEP;
            cpu_ce_q <= 1'b1;
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  logic [1:0]  disp_src_q;
  logic [31:0] disp_data_q;
  logic [31:0] disp_mux;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    disp_mux = 32'd0;
    case (disp_src_q)
      2'd0:    disp_mux = pc;
      2'd1:    disp_mux = instr;
      2'd2:    disp_mux = data_out;
      default: disp_mux = 32'(cnt_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_src_q  <= 2'd0;
      disp_data_q <= 32'd0;
    end else begin
      if (disp_press) disp_src_q <= disp_src_q + 2'd1;
      disp_data_q <= disp_mux;
    end
  end

  assign cpu_ce    = cpu_ce_q;
  assign cycle_cnt = cnt_q;
  assign disp_src  = disp_src_q;
  assign disp_data = disp_data_q;
  assign state     = state_q;
  assign halted    = (state_q != ST_RUN);

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Execution controller between the board clock and the pipelined CPU; replaces the free-running divided clock with a single-clock, clock-enable scheme.
- Schedules CPU advance in four modes: free-run at a divided rate, single-step from a push button, halt, and PC breakpoint.
- Owns the 7-segment display source: a second button rotates the display through PC, instruction, data_out and the retired-cycle counter.

Parameters:
DIV_LOG2, 20, run-mode tick period = 2^DIV_LOG2 clk cycles
DEB_CYCLES, 1000000, consecutive stable samples required to accept a button level
CNT_W, 32, cycle counter width (must be <= 32)

Ports:
clk  in  1  board clock; all logic on rising edge
rst  in  1  synchronous reset, active-low
mode_run  in  1  slide switch: 1 = run, 0 = stop/step
btn_step  in  1  raw step button, asynchronous
btn_disp  in  1  raw display-select button, asynchronous
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
pc  in  32  CPU current PC
instr  in  32  CPU current instruction
data_out  in  32  CPU debug data
cpu_ce  out  1  CPU clock enable; one-cycle pulse per CPU step
cycle_cnt  out  CNT_W  number of cpu_ce pulses issued
disp_src  out  2  0 = pc, 1 = instr, 2 = data_out, 3 = cycle_cnt
disp_data  out  32  value for Seg7x16 i_data
state  out  2  0 = HALT, 1 = RUN, 2 = STEP, 3 = BREAK
halted  out  1  1 whenever state != RUN

Behaviour:
- Reset (rst == 0 at a clk edge): state = HALT, cpu_ce = 0, cycle_cnt = 0, disp_src = 0, disp_data = 0, divider = 0.
  - Synchronizers, debounce counters and debounced levels are all cleared to 0.
  - Reset mid-operation aborts any pending tick or step.
- Button conditioning, per button:
  - 2-FF synchronizer.
  - Debounce counter counts consecutive samples differing from the debounced level; at DEB_CYCLES samples the level flips and the counter clears. Any equal sample clears the counter.
  - A 0->1 flip of the debounced level produces a one-cycle press pulse.
  - A button held through reset gives exactly one press after 2 + DEB_CYCLES cycles.
- FSM (registered; transition checks in the priority order listed):
  - HALT:
    - mode_run = 1 -> RUN (divider cleared).
    - else step press -> STEP.
  - RUN:
    - mode_run = 0 -> HALT.
    - else bp_en and pc == bp_addr -> BREAK; cpu_ce suppressed that cycle.
    - else divider increments; when divider == all-ones, cpu_ce = 1 on the next cycle.
    - Step presses are ignored.
  - STEP: cpu_ce = 1 for exactly this one cycle; next state HALT unconditionally.
  - BREAK:
    - mode_run = 0 -> HALT.
    - else step press -> STEP. The step executes past the breakpoint; HALT then re-enters RUN if mode_run is still 1.
    - No cpu_ce is issued while in BREAK.
- cpu_ce:
  - Registered; never high on two consecutive cycles in RUN when DIV_LOG2 >= 1.
  - A pending RUN tick is dropped if mode_run falls in the same cycle.
- cycle_cnt increments by 1 on each cycle cpu_ce = 1 and wraps from 2^CNT_W - 1 to 0.
- Display:
  - A disp press increments disp_src modulo 4.
  - disp_data is registered with a 1-cycle latency from the mux of pc / instr / data_out / zero-extended cycle_cnt, selected by the current disp_src.
  - Display presses work in every state.
- Simultaneous events: reset > mode_run > breakpoint > tick/step.

Test Plan (DIV_LOG2 = 2, DEB_CYCLES = 4, CNT_W = 8):
- Release reset with mode_run = 0, no buttons -> state = 0, cpu_ce never high over 50 cycles, cycle_cnt = 0, halted = 1.
- Set mode_run = 1 -> cpu_ce pulses every 4 cycles, one cycle wide; after 10 pulses cycle_cnt = 10; halted = 0.
- With mode_run = 0, hold btn_step for 3 cycles then release -> no step (bounce rejected). Hold for 8 cycles -> exactly one cpu_ce pulse, state HALT->STEP->HALT, cycle_cnt +1.
- Run with bp_en = 1, bp_addr = 0x0000000C; bench advances pc by 4 per cpu_ce from 0 -> after the 3rd pulse state = BREAK, no further cpu_ce. A step press gives exactly one pulse, then RUN resumes.
- Preload cycle_cnt to 255 via 255 pulses, issue one more -> cycle_cnt = 0. Press btn_disp 3 times -> disp_src = 3 and disp_data = 0x00000000 one cycle after the select.
- Assert rst low for one cycle mid-RUN while a tick is pending -> next cycle state = 0, cpu_ce = 0, cycle_cnt = 0, disp_src = 0.
